// File: rtl/cgia_fetcher.sv
// -----------------------------------------------------------------------------
// cgia_fetcher -- scanline fetch DMA engine of the CGIA video core.
//
// A non-pipelined Wishbone master. On each qualifying HSYNC it reads
// line_len_i 16-bit words from the frame buffer and strobes each accepted word
// into the active line buffer. The fetch pointer carries over from line to
// line and is reloaded from fb_adr_i only by VSYNC.
//
// Ports:
//   clk_i       Wishbone SYSCON clock (rising edge)
//   reset_i     asynchronous active-low reset
//   hsync_i     CRTC horizontal sync; it starts one burst per assertion
//   vsync_i     CRTC vertical sync; it reloads the fetch pointer
//   den_i       display enable; it qualifies the start of a burst
//   fb_adr_i    frame-buffer start word address [23:1]
//   line_len_i  words per line [9:1]; 0 disables fetching
//   ack_i       Wishbone acknowledge
//   cyc_o       Wishbone CYC, which also serves as STB
//   adr_o       Wishbone word address [23:1]
//   s_we_o      line-buffer write strobe; high when a word is accepted
//
// Build option:
//   CGIA_FETCHER_VSYNC_ABORT_EN  When defined, VSYNC during a burst aborts the
//                                burst at once. When undefined, the burst
//                                finishes and the pointer reload waits for the
//                                first idle edge that still sees VSYNC.
// -----------------------------------------------------------------------------
module cgia_fetcher (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        den_i,
  input  logic [23:1] fb_adr_i,
  input  logic [9:1]  line_len_i,
  input  logic        ack_i,
  output logic        cyc_o,
  output logic [23:1] adr_o,
  output logic        s_we_o
);

  logic [23:1] ptr;
  logic [9:1]  cnt;
  logic        busy;
  logic        armed;
  logic        start;

  // Start is a level condition. "armed" limits each HSYNC assertion to one
  // burst, even when den_i arrives late in the pulse.
  assign start = hsync_i & den_i & ~armed & ~busy & ~vsync_i & (line_len_i != 9'd0);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ptr   <= 23'd0;
      cnt   <= 9'd0;
      busy  <= 1'b0;
      armed <= 1'b0;
    end else begin
      if (!hsync_i)
        armed <= 1'b0;
`ifdef CGIA_FETCHER_VSYNC_ABORT_EN
      // VSYNC takes priority over everything. An in-flight burst is dropped,
      // and any ack on this edge is ignored.
      if (vsync_i) begin
        ptr  <= fb_adr_i;
        busy <= 1'b0;
        cnt  <= 9'd0;
      end else if (busy) begin
        if (ack_i) begin
          ptr <= ptr + 23'd1;
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1)
            busy <= 1'b0;
        end
      end else if (start) begin
        busy  <= 1'b1;
        armed <= 1'b1;
        cnt   <= line_len_i;
      end
`else
      // A running burst ignores VSYNC. The reload happens once the engine is
      // idle, provided vsync_i is still high at that time.
      if (busy) begin
        if (ack_i) begin
          ptr <= ptr + 23'd1;
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1)
            busy <= 1'b0;
        end
      end else if (vsync_i) begin
        ptr <= fb_adr_i;
      end else if (start) begin
        busy  <= 1'b1;
        armed <= 1'b1;
        cnt   <= line_len_i;
      end
`endif
    end
  end

  assign cyc_o  = busy;
  assign adr_o  = ptr;
  assign s_we_o = busy & ack_i;

endmodule

// File: tb/tb_cgia_fetcher.sv
module tb_cgia_fetcher;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        hsync_i, vsync_i, den_i, ack_i;
  logic [23:1] fb_adr_i;
  logic [9:1]  line_len_i;
  logic        cyc_o, s_we_o;
  logic [23:1] adr_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [22:0] exp_q[$];

  cgia_fetcher dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .den_i      (den_i),
    .fb_adr_i   (fb_adr_i),
    .line_len_i (line_len_i),
    .ack_i      (ack_i),
    .cyc_o      (cyc_o),
    .adr_o      (adr_o),
    .s_we_o     (s_we_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the active edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Sample outputs on the falling edge.
  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic push_words(input logic [22:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 23'(i));
  endtask

  // Scoreboard monitor: every line-buffer write must match the next expected word address.
  always @(negedge clk_i) begin
    if (s_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got adr 0x%0h, expected no write at %0t", adr_o, $time);
      end else begin
        chk("write_adr", {9'd0, adr_o}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; den_i = 1'b0; ack_i = 1'b0;
    fb_adr_i = 23'd0; line_len_i = 9'd0;

    // Reset state, both during reset and after its release
    sample(); sample();
    chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
    chk("rst_adr", {9'd0, adr_o}, 32'd0);
    chk("rst_swe", {31'd0, s_we_o}, 32'd0);
    tick(); reset_i = 1'b1;
    tick(); sample();
    chk("post_rst_cyc", {31'd0, cyc_o}, 32'd0);

    // VSYNC loads the frame-buffer base (byte address 0xFF0000)
    tick(); fb_adr_i = 23'h7F8000; vsync_i = 1'b1;
    tick(); vsync_i = 1'b0;
    sample();
    chk("vsync_adr", {9'd0, adr_o}, 32'h7F8000);
    chk("vsync_cyc", {31'd0, cyc_o}, 32'd0);

    // HSYNC with DEN low does not start; a late DEN within the same HSYNC does
    tick(); line_len_i = 9'd6; hsync_i = 1'b1; den_i = 1'b0; ack_i = 1'b0;
    sample(); chk("den0_cyc_a", {31'd0, cyc_o}, 32'd0);
    tick(); sample(); chk("den0_cyc_b", {31'd0, cyc_o}, 32'd0);
    tick(); den_i = 1'b1; ack_i = 1'b1;
    push_words(23'h7F8000, 6);
    tick(); ack_i = 1'b1;
    sample();
    chk("start_cyc", {31'd0, cyc_o}, 32'd1);
    chk("start_adr", {9'd0, adr_o}, 32'h7F8000);
    // Three wait states after the first word
    for (int i = 0; i < 3; i++) begin
      tick(); ack_i = 1'b0;
      sample();
      chk("wait_adr", {9'd0, adr_o}, 32'h7F8001);
      chk("wait_swe", {31'd0, s_we_o}, 32'd0);
      chk("wait_cyc", {31'd0, cyc_o}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      tick(); ack_i = 1'b1;
    end
    tick(); ack_i = 1'b0;
    sample();
    chk("burst_end_cyc", {31'd0, cyc_o}, 32'd0);
    chk("burst_end_adr", {9'd0, adr_o}, 32'h7F8006);

    // Idle with HSYNC low: no new burst
    tick(); hsync_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      chk("idle_cyc", {31'd0, cyc_o}, 32'd0);
    end

    // The second line resumes at byte address 0xFF000C
    tick(); line_len_i = 9'd2; hsync_i = 1'b1; ack_i = 1'b1;
    push_words(23'h7F8006, 2);
    tick(); sample();
    chk("line2_cyc", {31'd0, cyc_o}, 32'd1);
    chk("line2_adr", {9'd0, adr_o}, 32'h7F8006);
    tick(); sample();
    tick(); sample();
    chk("line2_end_cyc", {31'd0, cyc_o}, 32'd0);
    tick(); hsync_i = 1'b0; ack_i = 1'b0;

    // VSYNC in the middle of a burst
    tick(); fb_adr_i = 23'h000100; line_len_i = 9'd4; hsync_i = 1'b1; ack_i = 1'b1;
`ifdef CGIA_FETCHER_VSYNC_ABORT_EN
    push_words(23'h7F8008, 1);
`else
    push_words(23'h7F8008, 4);
`endif
    tick();
    tick(); vsync_i = 1'b1; ack_i = 1'b0;
    sample();
    tick(); ack_i = 1'b1;
    sample();
`ifdef CGIA_FETCHER_VSYNC_ABORT_EN
    chk("vabort_cyc", {31'd0, cyc_o}, 32'd0);
    chk("vabort_adr", {9'd0, adr_o}, 32'h000100);
`else
    chk("vhold_cyc", {31'd0, cyc_o}, 32'd1);
    chk("vhold_adr", {9'd0, adr_o}, 32'h7F8009);
`endif
    for (int i = 0; i < 4; i++) tick();
    vsync_i = 1'b0; hsync_i = 1'b0; ack_i = 1'b0;
    sample();
    chk("vsync_mid_cyc", {31'd0, cyc_o}, 32'd0);
    chk("vsync_mid_adr", {9'd0, adr_o}, 32'h000100);

    // A zero line length never starts a burst
    tick(); line_len_i = 9'd0; hsync_i = 1'b1; ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); sample();
      chk("len0_cyc", {31'd0, cyc_o}, 32'd0);
    end
    tick(); hsync_i = 1'b0; ack_i = 1'b0;

    // Reset in the middle of a burst aborts it immediately
    tick(); line_len_i = 9'd5; hsync_i = 1'b1; ack_i = 1'b1;
    push_words(23'h000100, 2);
    tick(); sample();
    chk("rstmid_cyc_before", {31'd0, cyc_o}, 32'd1);
    tick(); sample();
    tick(); #2 reset_i = 1'b0;
    #1;
    chk("rstmid_cyc", {31'd0, cyc_o}, 32'd0);
    chk("rstmid_adr", {9'd0, adr_o}, 32'd0);
    chk("rstmid_swe", {31'd0, s_we_o}, 32'd0);
    hsync_i = 1'b0; ack_i = 1'b0;
    tick(); tick(); reset_i = 1'b1;
    sample();
    chk("rstmid_release_cyc", {31'd0, cyc_o}, 32'd0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cgia_fetcher.md
# cgia_fetcher

Line-fetch DMA engine of the CGIA video core. It is a non-pipelined Wishbone bus master that reads a fixed number of 16-bit words per scanline from the frame buffer. It deposits each word as-is into the active line buffer by pulsing a write strobe. The CRTC (HSYNC/VSYNC) and the register set (DEN, frame-buffer base, line length) cue it.

## Interface
Parameters: none.
- clk_i  in  1  Wishbone SYSCON clock; all state changes on rising edge.
- reset_i  in  1  Asynchronous, active-low reset.
- hsync_i  in  1  CRTC horizontal sync, active high.
- vsync_i  in  1  CRTC vertical sync, active high.
- den_i  in  1  Display enable from REGSET.
- fb_adr_i  in  23 [23:1]  Frame-buffer start word address.
- line_len_i  in  9 [9:1]  Line length in bytes, bit 0 dropped; this equals the word count per line.
- ack_i  in  1  Wishbone cycle acknowledge from the memory slave.
- cyc_o  out  1  Wishbone cycle request/in progress; doubles as STB.
- adr_o  out  23 [23:1]  Wishbone word address; equals the internal fetch pointer.
- s_we_o  out  1  Line-buffer write enable; high in the cycle a word is accepted.

## Operation
- Registers:
  - ptr[23:1]: fetch pointer, drives adr_o.
  - cnt[9:1]: words remaining.
  - busy: drives cyc_o.
  - armed: set when a line has been started; cleared while hsync_i is low.
- VSYNC: any clock edge with vsync_i=1 loads ptr <= fb_adr_i. Priority: VSYNC over start and transfer (see Configuration).
- Start condition: hsync_i & den_i & ~armed & ~busy & ~vsync_i & line_len_i != 0. On that edge:
  - busy <= 1 and armed <= 1.
  - cnt <= line_len_i.
  - ptr is unchanged. The pointer carries over from the previous line and is reloaded only by VSYNC.
- Start is level-qualified, not edge-triggered:
  - If HSYNC rises with den_i=0, a later den_i=1 while HSYNC is still high starts the line.
  - Only one burst starts per HSYNC assertion.
- Transfer: an edge with busy & ack_i does ptr <= ptr+1 (mod 2^23) and cnt <= cnt-1. If cnt==1, busy <= 0.
- Wait states: busy & ~ack_i holds ptr, cnt and busy unchanged, for any number of cycles.
- s_we_o = cyc_o & ack_i (combinational). Data is captured by the line buffer at the same edge the pointer advances.
- hsync_i asserted during a burst is ignored. den_i dropping mid-burst does not abort the burst.
- line_len_i = 0: no burst; cyc_o stays 0.

## Timing
- Reset values (asynchronous, while reset_i=0): cyc_o=0, s_we_o=0, adr_o=0, cnt=0, armed=0.
- cyc_o rises one edge after the start condition is sampled.
- Each transfer takes one cycle at zero wait states.
- The burst of N words completes N ack'd cycles after cyc_o rises. cyc_o is 0 immediately after the edge that accepts word N.
- After a burst, cyc_o stays 0 until the next qualifying HSYNC.
- Reset mid-burst aborts immediately; cyc_o=0 and the pointer returns to 0.

## Configuration
- CGIA_FETCHER_VSYNC_ABORT_EN defined:
  - vsync_i=1 during a burst aborts it: busy <= 0, cnt <= 0, ptr <= fb_adr_i.
  - The same edge produces no transfer increment.
- Not defined:
  - A VSYNC during a burst is ignored until busy=0.
  - While busy, the ptr load is suppressed and transfers proceed normally.
  - The reload happens on the first idle edge with vsync_i=1.

## Test plan
- Reset: reset_i=0, then release -> cyc_o=0 both during and after reset.
- fb_adr_i=0x7F8000 (byte 0xFF0000), vsync_i=1 for one cycle -> adr_o byte address 0xFF0000, cyc_o=0.
- hsync_i=1, den_i=0 -> cyc_o=0. Then den_i=1 with hsync_i still 1 -> cyc_o=1, address 0xFF0000.
- line_len_i=6, ack_i=1 except 3 wait cycles after the first word:
  - Address stays 0xFF0002 with s_we_o=0 during the waits.
  - Then 0xFF0004, 0xFF0006, 0xFF0008, 0xFF000A.
  - cyc_o=0 after the 6th ack.
- After the burst, 4+ idle cycles with hsync_i=0 -> cyc_o stays 0. A second HSYNC resumes at 0xFF000C.
- vsync_i=1 mid-burst:
  - With the macro defined: cyc_o=0 next cycle, address = fb_adr_i.
  - Without it: the burst finishes, then the address reloads.
